// File: rtl/lcd_frame_streamer.sv
// Raster pixel source for the LT24 ILI9341 write driver: 320x240 scan, centred upscaled 28x28 canvas.
// Optional cursor overlay is enabled by defining LCD_STREAM_CURSOR_EN.
module lcd_frame_streamer #(
    parameter int unsigned H_RES        = 320,
    parameter int unsigned V_RES        = 240,
    parameter int unsigned CANVAS_DIM   = 28,
    parameter int unsigned SCALE        = 8,
    parameter int unsigned X0           = 48,
    parameter int unsigned Y0           = 8,
    parameter logic [15:0] FG_COLOR     = 16'hFFFF,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter logic [15:0] BORDER_COLOR = 16'h4208,
    parameter logic [15:0] CURSOR_COLOR = 16'hF800
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    enable,
    input  logic                                    initialized,
    input  logic                                    done,
`ifdef LCD_STREAM_CURSOR_EN
    input  logic [8:0]                              cursor_x,
    input  logic [7:0]                              cursor_y,
`endif
    output logic [15:0]                             pixel_rgb,
    output logic                                    print,
    output logic [$clog2(CANVAS_DIM*CANVAS_DIM)-1:0] canvas_addr,
    input  logic                                    canvas_rdata,
    output logic                                    frame_start,
    output logic                                    frame_done
);

    localparam int unsigned XW     = $clog2(H_RES);
    localparam int unsigned YW     = $clog2(V_RES);
    localparam int unsigned CW     = $clog2(CANVAS_DIM);
    localparam int unsigned SW     = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned AW     = $clog2(CANVAS_DIM*CANVAS_DIM);
    localparam int unsigned REGION = CANVAS_DIM * SCALE;

    localparam logic [XW-1:0] X_LAST = XW'(H_RES - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_RES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CANVAS_DIM - 1);
    localparam logic          ORIGIN_IN_REGION = (X0 == 0) && (Y0 == 0);

    if (X0 + REGION > H_RES) begin : g_chk_x
        $error("lcd_frame_streamer: canvas region exceeds H_RES");
    end
    if (Y0 + REGION > V_RES) begin : g_chk_y
        $error("lcd_frame_streamer: canvas region exceeds V_RES");
    end

    typedef enum logic [1:0] {
        WAIT_INIT = 2'd0,
        FETCH     = 2'd1,
        PRESENT   = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [SW-1:0] sx_q, sx_d, sy_q, sy_d;
    logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          in_region_q, in_region_d;
    logic          frame_start_q, frame_start_d;
    logic          frame_done_q, frame_done_d;
    logic          xfer;
    logic          col_in, row_in;

    function automatic logic in_span(input int unsigned v, input int unsigned lo,
                                     input int unsigned len);
        return (v >= lo) && (v < lo + len);
    endfunction

    assign print       = (state_q == PRESENT) && enable && initialized;
    assign xfer        = print && done;
    assign col_in      = in_span(32'(x_q), X0, REGION);
    assign row_in      = in_span(32'(y_q), Y0, REGION);
    assign canvas_addr = row_base_q + AW'(cx_q);
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

`ifdef LCD_STREAM_CURSOR_EN
    logic [8:0]         cursor_x_q, cursor_x_d;
    logic [7:0]         cursor_y_q, cursor_y_d;
    logic signed [31:0] cur_dx, cur_dy;
    logic               cursor_hit;

    // Differences are taken in full signed width so the box clips at screen edges instead of wrapping.
    assign cur_dx     = $signed(32'(x_q)) - $signed(32'(cursor_x_q));
    assign cur_dy     = $signed(32'(y_q)) - $signed(32'(cursor_y_q));
    assign cursor_hit = (cur_dx >= -2) && (cur_dx <= 2) && (cur_dy >= -2) && (cur_dy <= 2);
`endif

    always_comb begin
        state_d       = state_q;
        x_d           = x_q;
        y_d           = y_q;
        sx_d          = sx_q;
        sy_d          = sy_q;
        cx_d          = cx_q;
        cy_d          = cy_q;
        row_base_d    = row_base_q;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
`ifdef LCD_STREAM_CURSOR_EN
        cursor_x_d    = cursor_x_q;
        cursor_y_d    = cursor_y_q;
`endif
        case (state_q)
            WAIT_INIT: begin
                if (initialized && enable) state_d = FETCH;
            end
            FETCH: begin
                state_d = PRESENT;
`ifdef LCD_STREAM_CURSOR_EN
                cursor_x_d = cursor_x;
                cursor_y_d = cursor_y;
`endif
            end
            PRESENT: begin
                if (xfer) begin
                    state_d       = FETCH;
                    frame_start_d = (x_q == '0) && (y_q == '0);
                    frame_done_d  = (x_q == X_LAST) && (y_q == Y_LAST);
                    if (x_q == X_LAST) begin
                        x_d  = '0;
                        sx_d = '0;
                        cx_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d        = '0;
                            sy_d       = '0;
                            cy_d       = '0;
                            row_base_d = '0;
                        end else begin
                            y_d = y_q + 1'b1;
                            // Cell row stops at the last canvas row so the address never leaves the RAM.
                            if (row_in) begin
                                if (sy_q == S_LAST) begin
                                    sy_d = '0;
                                    if (cy_q != C_LAST) begin
                                        cy_d       = cy_q + 1'b1;
                                        row_base_d = row_base_q + AW'(CANVAS_DIM);
                                    end
                                end else begin
                                    sy_d = sy_q + 1'b1;
                                end
                            end
                        end
                    end else begin
                        x_d = x_q + 1'b1;
                        if (col_in) begin
                            if (sx_q == S_LAST) begin
                                sx_d = '0;
                                if (cx_q != C_LAST) cx_d = cx_q + 1'b1;
                            end else begin
                                sx_d = sx_q + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_d = WAIT_INIT;
        endcase

        // Losing the driver's init (e.g. driver reset) restarts the raster from the origin.
        if (!initialized) begin
            state_d    = WAIT_INIT;
            x_d        = '0;
            y_d        = '0;
            sx_d       = '0;
            sy_d       = '0;
            cx_d       = '0;
            cy_d       = '0;
            row_base_d = '0;
        end

        in_region_d = in_span(32'(x_d), X0, REGION) && in_span(32'(y_d), Y0, REGION);
    end

    always_comb begin
        pixel_rgb = 16'h0000;
        if (state_q == PRESENT) begin
            if (!in_region_q)       pixel_rgb = BORDER_COLOR;
            else if (canvas_rdata)  pixel_rgb = FG_COLOR;
            else                    pixel_rgb = BG_COLOR;
`ifdef LCD_STREAM_CURSOR_EN
            if (cursor_hit) pixel_rgb = CURSOR_COLOR;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= WAIT_INIT;
            x_q           <= '0;
            y_q           <= '0;
            sx_q          <= '0;
            sy_q          <= '0;
            cx_q          <= '0;
            cy_q          <= '0;
            row_base_q    <= '0;
            in_region_q   <= ORIGIN_IN_REGION;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
`ifdef LCD_STREAM_CURSOR_EN
            cursor_x_q    <= '0;
            cursor_y_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            sx_q          <= sx_d;
            sy_q          <= sy_d;
            cx_q          <= cx_d;
            cy_q          <= cy_d;
            row_base_q    <= row_base_d;
            in_region_q   <= in_region_d;
            frame_start_q <= frame_start_d;
            frame_done_q  <= frame_done_d;
`ifdef LCD_STREAM_CURSOR_EN
            cursor_x_q    <= cursor_x_d;
            cursor_y_q    <= cursor_y_d;
`endif
        end
    end

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Scoreboard bench for lcd_frame_streamer on a reduced raster; expected pixels come from a
// coordinate-level model (division-based cell lookup) and are popped by an independent monitor.
module tb_lcd_frame_streamer;

    localparam int H   = 32;
    localparam int V   = 24;
    localparam int CD  = 5;
    localparam int SC  = 4;
    localparam int X0  = 6;
    localparam int Y0  = 2;
    localparam int AW  = $clog2(CD*CD);
    localparam logic [15:0] FG     = 16'hFFFF;
    localparam logic [15:0] BG     = 16'h0000;
    localparam logic [15:0] BORDER = 16'h4208;
    localparam logic [15:0] CURSOR = 16'hF800;

    logic          clk = 1'b0;
    logic          reset, enable, initialized, done;
    logic          canvas_rdata = 1'b0;
    logic          print, frame_start, frame_done;
    logic [15:0]   pixel_rgb;
    logic [AW-1:0] canvas_addr;
`ifdef LCD_STREAM_CURSOR_EN
    logic [8:0]    cursor_x = '0;
    logic [7:0]    cursor_y = '0;
`endif

    logic canvas_mem [CD*CD];
    int   checks   = 0;
    int   failures = 0;
    int   cycle    = 0;

    typedef struct {
        int          x;
        int          y;
        logic [15:0] rgb;
        bit          in_reg;
        int          addr;
    } pix_t;

    pix_t exp_q[$];
    int   fs_cycles[$];
    int   mx = 0;
    int   my = 0;

    lcd_frame_streamer #(
        .H_RES(H), .V_RES(V), .CANVAS_DIM(CD), .SCALE(SC), .X0(X0), .Y0(Y0),
        .FG_COLOR(FG), .BG_COLOR(BG), .BORDER_COLOR(BORDER), .CURSOR_COLOR(CURSOR)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .initialized(initialized),
        .done(done),
`ifdef LCD_STREAM_CURSOR_EN
        .cursor_x(cursor_x),
        .cursor_y(cursor_y),
`endif
        .pixel_rgb(pixel_rgb),
        .print(print),
        .canvas_addr(canvas_addr),
        .canvas_rdata(canvas_rdata),
        .frame_start(frame_start),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle        <= cycle + 1;
        canvas_rdata <= (int'(canvas_addr) < CD*CD) ? canvas_mem[canvas_addr] : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    function automatic pix_t model(input int x, input int y);
        pix_t p;
        p.x      = x;
        p.y      = y;
        p.in_reg = (x >= X0) && (x < X0 + CD*SC) && (y >= Y0) && (y < Y0 + CD*SC);
        p.addr   = p.in_reg ? ((y - Y0) / SC) * CD + (x - X0) / SC : 0;
        if (!p.in_reg)                p.rgb = BORDER;
        else if (canvas_mem[p.addr])  p.rgb = FG;
        else                          p.rgb = BG;
`ifdef LCD_STREAM_CURSOR_EN
        if (x - int'(cursor_x) >= -2 && x - int'(cursor_x) <= 2 &&
            y - int'(cursor_y) >= -2 && y - int'(cursor_y) <= 2)
            p.rgb = CURSOR;
`endif
        return p;
    endfunction

    task automatic push_pixels(input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(model(mx, my));
            if (mx == H - 1) begin
                mx = 0;
                my = (my == V - 1) ? 0 : my + 1;
            end else begin
                mx++;
            end
        end
    endtask

    // mode 0: done/enable held; mode 1: random done and enable
    task automatic drain(input int mode, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            #1;
            n++;
            if (mode == 1) begin
                done   = ($urandom_range(0, 2) != 0);
                enable = ($urandom_range(0, 7) != 0);
            end
        end
        done   = 1'b0;
        enable = 1'b1;
        check("drain_remaining", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: pops the scoreboard on every handshake and checks pulses and hold stability.
    initial begin
        bit          exp_fs = 0, exp_fd = 0, hold_prev = 0;
        logic [15:0] prev_rgb = '0;
        logic [AW-1:0] prev_addr = '0;
        pix_t        p;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("frame_start", frame_start, exp_fs);
                check("frame_done", frame_done, exp_fd);
                if (frame_start) fs_cycles.push_back(cycle);
                exp_fs = 0;
                exp_fd = 0;
                if (hold_prev && enable && initialized) begin
                    check("hold_print", print, 1);
                    check("hold_rgb", pixel_rgb, prev_rgb);
                    check("hold_addr", canvas_addr, prev_addr);
                end
                if (print && done) begin
                    check("transfer_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        p = exp_q.pop_front();
                        check($sformatf("rgb(%0d,%0d)", p.x, p.y), pixel_rgb, p.rgb);
                        if (p.in_reg)
                            check($sformatf("addr(%0d,%0d)", p.x, p.y), canvas_addr, p.addr);
                        exp_fs = (p.x == 0) && (p.y == 0);
                        exp_fd = (p.x == H - 1) && (p.y == V - 1);
                    end
                end
                hold_prev = print && !done;
                prev_rgb  = pixel_rgb;
                prev_addr = canvas_addr;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        reset       = 1'b1;
        enable      = 1'b0;
        initialized = 1'b0;
        done        = 1'b0;
        for (int i = 0; i < CD*CD; i++) canvas_mem[i] = 1'($urandom_range(0, 1));
        canvas_mem[CD + 1] = 1'b1;
        canvas_mem[CD]     = 1'b0;

        repeat (2) @(negedge clk);
        check("reset_print", print, 0);
        check("reset_rgb", pixel_rgb, 0);
        check("reset_addr", canvas_addr, 0);
        check("reset_frame_start", frame_start, 0);
        check("reset_frame_done", frame_done, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Not initialised: no request may appear even with enable and done high.
        enable = 1'b1;
        done   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("no_init_print", print, 0);
        end

        // Full frame plus the head of the next at full rate.
        push_pixels(H*V + 10);
        @(posedge clk);
        #1 initialized = 1'b1;
        lat = 0;
        while (!print && lat < 10) begin
            @(posedge clk);
            #1 lat++;
        end
        check("first_print_latency", lat, 2);
        drain(0, 4*H*V);
        check("frame_start_count", fs_cycles.size(), 2);
        if (fs_cycles.size() >= 2)
            check("frame_period", fs_cycles[1] - fs_cycles[0], 2*H*V);

        // Random handshake and enable pauses.
        push_pixels(300);
        drain(1, 5000);

        // Long done=0 hold while a pixel is presented.
        push_pixels(2);
        done = 1'b0;
        repeat (12) @(posedge clk);
        #1 done = 1'b1;
        drain(0, 100);

        // Enable pause of 7 cycles with done high.
        push_pixels(5);
        enable = 1'b0;
        done   = 1'b1;
        repeat (7) @(posedge clk);
        #1 enable = 1'b1;
        drain(0, 100);

        // Driver re-init mid-frame restarts the raster at the origin.
        @(posedge clk);
        #1 initialized = 1'b0;
        @(negedge clk);
        check("deinit_print", print, 0);
        repeat (3) @(posedge clk);
        mx = 0;
        my = 0;
        push_pixels(40);
        #1 initialized = 1'b1;
        done = 1'b1;
        drain(0, 400);

        // New canvas content, then run through the frame end and into the next frame.
        for (int i = 0; i < CD*CD; i++) canvas_mem[i] = 1'($urandom_range(0, 1));
        repeat (2) @(posedge clk);
        #1;
        push_pixels(H*V - (my*H + mx) + 20);
        done = 1'b1;
        drain(1, 8*H*V);

        repeat (4) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
